// File: rtl/edge_pulse_gen.sv
// Rising-edge pulse transmitter: turns 1-cycle trig requests into fixed-width pulses
// with a guaranteed low gap, queueing extra requests. Optional abort port: EDGE_GEN_ABORT_EN.
module edge_pulse_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef EDGE_GEN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              trig,
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]     HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]     LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [PEND_W-1:0]   pend_nxt;
  logic                ovf_nxt;
  logic                have_req;
  logic                start;
  logic                inc;
  logic                dec;

  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = (timer != '0) ? timer - 1'b1 : timer;
    pend_nxt  = pend_cnt;
    ovf_nxt   = 1'b0;
    start     = 1'b0;
    have_req  = trig || (pend_cnt != '0);

    unique case (state)
      IDLE: if (have_req) start = 1'b1;
      HIGH: if (timer == '0) begin
        state_nxt = LOW;
        timer_nxt = LOW_LOAD;
      end
      LOW: if (timer == '0) begin
        if (have_req) start = 1'b1;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      state_nxt = HIGH;
      timer_nxt = HIGH_LOAD;
    end

    // A trig that launches a pulse with an empty queue is consumed directly.
    dec = start && (pend_cnt != '0);
    inc = trig && !(start && (pend_cnt == '0));

    if (inc && !dec) begin
      if (pend_cnt == PEND_MAX) ovf_nxt  = 1'b1;
      else                      pend_nxt = pend_cnt + 1'b1;
    end else if (dec && !inc) begin
      pend_nxt = pend_cnt - 1'b1;
    end

`ifdef EDGE_GEN_ABORT_EN
    // Abort outranks trig and queued work: flush the queue and force a full low gap.
    if (abort) begin
      pend_nxt = '0;
      ovf_nxt  = 1'b0;
      if (state == IDLE) begin
        state_nxt = IDLE;
        timer_nxt = timer;
      end else begin
        state_nxt = LOW;
        timer_nxt = LOW_LOAD;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
      sig_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      pend_cnt <= pend_nxt;
      overflow <= ovf_nxt;
      sig_out  <= (state_nxt == HIGH);
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed self-checking bench for edge_pulse_gen at default parameters (HIGH=4, LOW=4, PEND_W=4).
// Define EDGE_GEN_ABORT_EN for both files to exercise the abort path.
`timescale 1ns/1ps
module tb_edge_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic       sig_out;
  logic       busy;
  logic [3:0] pend_cnt;
  logic       overflow;
`ifdef EDGE_GEN_ABORT_EN
  logic       abort;
`endif

  int checks;
  int failures;
  int rise_cnt;
  int ovf_cnt;
  logic prev_sig;

  edge_pulse_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef EDGE_GEN_ABORT_EN
    .abort    (abort),
`endif
    .trig     (trig),
    .sig_out  (sig_out),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: counts rising edges of sig_out and overflow-high cycles.
  initial begin
    rise_cnt = 0;
    ovf_cnt  = 0;
    prev_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_out && !prev_sig) rise_cnt++;
      if (overflow) ovf_cnt++;
      prev_sig = sig_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      trig = i[0];
      tick();
      checks++;
      if ({sig_out, busy, pend_cnt, overflow} !== 7'b0) begin
        failures++;
        $display("FAIL reset_hold: got sig=%b busy=%b pend=%0d ovf=%b, expected all 0",
                 sig_out, busy, pend_cnt, overflow);
      end
    end
    trig  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sig_out, busy, pend_cnt, overflow} !== 7'b0) begin
        failures++;
        $display("FAIL reset_release: got sig=%b busy=%b pend=%0d ovf=%b, expected all 0",
                 sig_out, busy, pend_cnt, overflow);
      end
    end
  endtask

  task automatic test_single();
    int r0;
    r0   = rise_cnt;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int rel = 1; rel <= 9; rel++) begin
      checks++;
      if (sig_out !== (rel <= 4) || busy !== (rel <= 8) || pend_cnt !== 4'd0) begin
        failures++;
        $display("FAIL single_rel%0d: got sig=%b busy=%b pend=%0d, expected sig=%b busy=%b pend=0",
                 rel, sig_out, busy, pend_cnt, rel <= 4, rel <= 8);
      end
      if (rel < 9) tick();
    end
    checks++;
    if (rise_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL single_edges: got %0d rising edges, expected 1", rise_cnt - r0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic       exp_sig;
    logic [3:0] exp_pend;
    trig = 1'b1;
    for (int rel = 1; rel <= 26; rel++) begin
      tick();
      if (rel >= 3) trig = 1'b0;
      exp_sig  = (rel >= 1 && rel <= 4) || (rel >= 9 && rel <= 12) || (rel >= 17 && rel <= 20);
      exp_pend = (rel == 1) ? 4'd0 : (rel == 2) ? 4'd1 : (rel <= 8) ? 4'd2 :
                 (rel <= 16) ? 4'd1 : 4'd0;
      checks++;
      if (sig_out !== exp_sig || busy !== (rel <= 24) || pend_cnt !== exp_pend) begin
        failures++;
        $display("FAIL b2b_rel%0d: got sig=%b busy=%b pend=%0d, expected sig=%b busy=%b pend=%0d",
                 rel, sig_out, busy, pend_cnt, exp_sig, rel <= 24, exp_pend);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    int r0;
    int o0;
    r0   = rise_cnt;
    o0   = ovf_cnt;
    trig = 1'b1;
    for (int rel = 1; rel <= 40; rel++) begin
      tick();
      if (rel == 40) trig = 1'b0;
      if (rel == 18) begin
        checks++;
        if (pend_cnt !== 4'd15 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL sat_rel18: got pend=%0d ovf=%b, expected pend=15 ovf=0", pend_cnt, overflow);
        end
      end
      if (rel == 19) begin
        checks++;
        if (pend_cnt !== 4'd15 || overflow !== 1'b1) begin
          failures++;
          $display("FAIL sat_rel19: got pend=%0d ovf=%b, expected pend=15 ovf=1", pend_cnt, overflow);
        end
      end
      if (rel == 25) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL sat_rel25: got ovf=%b, expected 0 (dec and inc together)", overflow);
        end
      end
    end
    checks++;
    if (pend_cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat_pend_end: got pend=%0d, expected 15", pend_cnt);
    end
    wait_idle("sat_drain", 400);
    checks++;
    if (ovf_cnt - o0 !== 20) begin
      failures++;
      $display("FAIL sat_ovf_cycles: got %0d, expected 20", ovf_cnt - o0);
    end
    checks++;
    if (rise_cnt - r0 !== 40 - (ovf_cnt - o0)) begin
      failures++;
      $display("FAIL sat_edges: got %0d rising edges, expected %0d", rise_cnt - r0, 40 - (ovf_cnt - o0));
    end
  endtask

  task automatic test_last_low_trig();
    trig = 1'b1;
    for (int rel = 1; rel <= 9; rel++) begin
      tick();
      trig = (rel <= 3 || rel == 8);
      if (rel == 8) begin
        checks++;
        if (pend_cnt !== 4'd3 || sig_out !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL lastlow_pre: got pend=%0d sig=%b busy=%b, expected pend=3 sig=0 busy=1",
                   pend_cnt, sig_out, busy);
        end
      end
    end
    checks++;
    if (sig_out !== 1'b1 || pend_cnt !== 4'd3) begin
      failures++;
      $display("FAIL lastlow_post: got sig=%b pend=%0d, expected sig=1 pend=3", sig_out, pend_cnt);
    end
    wait_idle("lastlow_drain", 200);
  endtask

  task automatic test_reset_mid_pulse();
    trig = 1'b1;
    for (int rel = 1; rel <= 10; rel++) begin
      tick();
      if (rel >= 4) trig = 1'b0;
    end
    checks++;
    if (sig_out !== 1'b1 || pend_cnt !== 4'd2) begin
      failures++;
      $display("FAIL midrst_pre: got sig=%b pend=%0d, expected sig=1 pend=2", sig_out, pend_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sig_out, busy, pend_cnt, overflow} !== 7'b0) begin
      failures++;
      $display("FAIL midrst_async: got sig=%b busy=%b pend=%0d ovf=%b, expected all 0",
               sig_out, busy, pend_cnt, overflow);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({sig_out, busy, pend_cnt} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_after: got sig=%b busy=%b pend=%0d, expected all 0", sig_out, busy, pend_cnt);
    end
  endtask

`ifdef EDGE_GEN_ABORT_EN
  task automatic test_abort();
    trig = 1'b1;
    tick();
    tick();
    trig  = 1'b1;
    abort = 1'b1;
    tick();
    trig  = 1'b0;
    abort = 1'b0;
    for (int rel = 3; rel <= 7; rel++) begin
      checks++;
      if (sig_out !== 1'b0 || busy !== (rel <= 6) || pend_cnt !== 4'd0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL abort_rel%0d: got sig=%b busy=%b pend=%0d ovf=%b, expected sig=0 busy=%b pend=0 ovf=0",
                 rel, sig_out, busy, pend_cnt, overflow, rel <= 6);
      end
      tick();
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    trig     = 1'b0;
`ifdef EDGE_GEN_ABORT_EN
    abort    = 1'b0;
`endif
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_last_low_trig();
    test_reset_mid_pulse();
`ifdef EDGE_GEN_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
